// File: rtl/bpred_pkg.sv
// Shared types for the branch-prediction controller: counter encoding,
// table entry layout and controller FSM states.
package bpred_pkg;

  // Entries store the widest possible tag; narrower tags are zero-extended.
  localparam int MAX_TAG_BITS = 30;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    ctr_e                    ctr;
    logic [31:0]             target;
  } entry_t;

  localparam ctr_e COUNTER_INIT = WEAK_NT;

  function automatic entry_t blank_entry();
    blank_entry = '{valid: 1'b0, tag: '0, ctr: COUNTER_INIT, target: '0};
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter: step toward taken or not-taken,
// holding at the strong ends.
module sat_counter2
  import bpred_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e nxt
);

  always_comb begin
    nxt = cur;
    unique case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/bpred_ctrl.sv
// Branch-prediction controller: direct-mapped counter/tag/target table with
// clear sequencing, 1-cycle lookup and resolved-branch update.
// Optional statistics counters are built when BPRED_STATS_EN is defined.
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        predict_valid,
  output logic        predict_hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  input  logic        flush_req,
  output logic        ready,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  state_e                  state, state_nxt;
  logic [INDEX_BITS-1:0]   clr_idx, clr_nxt;
  entry_t                  tbl [ENTRIES];

  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [MAX_TAG_BITS-1:0] lk_tag, up_tag;
  entry_t                  rd_lk, rd_up, wr_up;
  logic                    lk_hit, up_hit, upd_acc;
  ctr_e                    ctr_step;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign lk_tag = MAX_TAG_BITS'(lookup_pc[31 -: TAG_BITS]);
  assign up_tag = MAX_TAG_BITS'(update_pc[31 -: TAG_BITS]);

  // FSM: CLEAR walks the table once, RUN serves updates
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_nxt;
      ready   <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_idx;
    unique case (state)
      CLEAR: begin
        clr_nxt = clr_idx + INDEX_BITS'(1);
        if (clr_idx == '1) begin
          state_nxt = RUN;
          clr_nxt   = '0;
        end
      end
      RUN:     ;
      default: state_nxt = CLEAR;
    endcase
    if (flush_req) begin
      state_nxt = CLEAR;
      clr_nxt   = '0;
    end
  end

  // Update path: flush wins over a same-cycle update
  assign upd_acc = update_valid && (state == RUN) && !flush_req;
  assign rd_up   = tbl[up_idx];
  assign up_hit  = rd_up.valid && (rd_up.tag == up_tag);

  sat_counter2 u_sat (
    .cur   (rd_up.ctr),
    .taken (update_taken),
    .nxt   (ctr_step)
  );

  always_comb begin
    wr_up = rd_up;
    if (up_hit) begin
      wr_up.ctr = ctr_step;
      if (update_taken) wr_up.target = update_target;
    end else begin
      wr_up.valid  = 1'b1;
      wr_up.tag    = up_tag;
      wr_up.target = update_target;
      wr_up.ctr    = update_taken ? WEAK_T : WEAK_NT;
    end
  end

  // Table storage has no reset; the CLEAR walk initialises it.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      tbl[clr_idx] <= blank_entry();
    else if (upd_acc)
      tbl[up_idx] <= wr_up;
  end

  // Lookup reads the pre-update contents and registers the result
  assign rd_lk  = tbl[lk_idx];
  assign lk_hit = lookup_valid && (state == RUN) && rd_lk.valid && (rd_lk.tag == lk_tag);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      predict_valid  <= 1'b0;
      predict_hit    <= 1'b0;
      predict_taken  <= 1'b0;
      predict_target <= '0;
    end else begin
      predict_valid  <= lookup_valid;
      predict_hit    <= lk_hit;
      predict_taken  <= lk_hit && rd_lk.ctr[1];
      predict_target <= lk_hit ? rd_lk.target : '0;
    end
  end

`ifdef BPRED_STATS_EN
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Statistics survive flushes; only reset clears them
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_acc) begin
      stat_updates <= stat_updates + 32'd1;
      if (update_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs    = ^{lookup_pc[1:0], update_pc[1:0], update_mispredict};
  assign stat_updates     = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bpred_ctrl.sv
// Bench for bpred_ctrl: directed vector table, flush sequence, then random
// traffic against an array-based reference model of the predictor table.
module tb_bpred_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_valid, predict_hit, predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush_req;
  logic        ready;
  logic [31:0] stat_updates, stat_mispredicts;

  always #5 clk = ~clk;

  bpred_ctrl #(.INDEX_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .predict_valid(predict_valid), .predict_hit(predict_hit),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .update_mispredict(update_mispredict), .flush_req(flush_req),
    .ready(ready), .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 16 entries, counters as plain ints 0..3
  bit          mv   [16];
  int          mc   [16];
  logic [31:0] mtag [16];
  logic [31:0] mtg  [16];
  int          clr_left;
  logic [31:0] m_su, m_sm;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) mv[k] = 1'b0;
    clr_left = 16;
    m_su = 0;
    m_sm = 0;
  endtask

  // One clock: drive, predict from the model, clock, advance model, compare
  task automatic cyc(input bit lv, input logic [31:0] lpc, input bit uv,
                     input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                     input bit um, input bit fl);
    int li, ui;
    bit acc, ev, eh, et;
    logic [31:0] etg;
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utg; update_mispredict = um; flush_req = fl;
    li = int'(lpc[5:2]);
    ev = lv; eh = 0; et = 0; etg = 0;
    if (lv && clr_left == 0 && mv[li] && mtag[li] == (lpc >> 6)) begin
      eh = 1; et = (mc[li] >= 2); etg = mtg[li];
    end
    acc = uv && clr_left == 0 && !fl;
    @(posedge clk);
    #1;
    if (acc) begin
      ui = int'(upc[5:2]);
      if (mv[ui] && mtag[ui] == (upc >> 6)) begin
        mc[ui] = ut ? ((mc[ui] == 3) ? 3 : mc[ui] + 1) : ((mc[ui] == 0) ? 0 : mc[ui] - 1);
        if (ut) mtg[ui] = utg;
      end else begin
        mv[ui] = 1; mtag[ui] = upc >> 6; mtg[ui] = utg; mc[ui] = ut ? 2 : 1;
      end
`ifdef BPRED_STATS_EN
      m_su = m_su + 1;
      if (um) m_sm = m_sm + 1;
`endif
    end
    if (fl) begin
      clr_left = 16;
      for (int k = 0; k < 16; k++) mv[k] = 1'b0;
    end else if (clr_left > 0) clr_left--;
    chk("m_valid",  {31'd0, predict_valid}, {31'd0, ev});
    chk("m_hit",    {31'd0, predict_hit},   {31'd0, eh});
    chk("m_taken",  {31'd0, predict_taken}, {31'd0, et});
    chk("m_target", predict_target, etg);
    chk("m_ready",  {31'd0, ready}, {31'd0, clr_left == 0});
    chk("m_stat_upd", stat_updates, m_su);
    chk("m_stat_mis", stat_mispredicts, m_sm);
  endtask

  typedef struct {
    bit lv; logic [31:0] lpc;
    bit uv; logic [31:0] upc; bit ut; logic [31:0] utg;
    bit e_v; bit e_h; bit e_t; logic [31:0] e_tg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut,
                              logic [31:0] utg, bit e_v, bit e_h, bit e_t, logic [31:0] e_tg);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg;
    v.e_v = e_v; v.e_h = e_h; v.e_t = e_t; v.e_tg = e_tg;
    return v;
  endfunction

  initial begin
    logic [31:0] su0, sm0;
    logic [31:0] pc;

    // Directed table: expected values are the prediction after each row's cycle
    vt.push_back(mk(0, 0,     1, 32'h100, 1, 32'h200, 0, 0, 0, 0));        // allocate, ctr 10
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 1, 32'h200));
    vt.push_back(mk(0, 0,     1, 32'h100, 1, 32'h200, 0, 0, 0, 0));        // 11
    vt.push_back(mk(0, 0,     1, 32'h100, 1, 32'h200, 0, 0, 0, 0));        // stays 11
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h0,   0, 0, 0, 0));        // 10
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 1, 32'h200));
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h0,   0, 0, 0, 0));        // 01
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h0,   0, 0, 0, 0));        // 00
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 0, 32'h200));
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h0,   0, 0, 0, 0));        // stays 00
    vt.push_back(mk(0, 0,     1, 32'h100, 1, 32'h200, 0, 0, 0, 0));        // 01, no wrap
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 0, 32'h200));
    vt.push_back(mk(0, 0,     1, 32'h500, 1, 32'h600, 0, 0, 0, 0));        // alias replaces
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 0, 0, 32'h0));
    vt.push_back(mk(1, 32'h500, 0, 0, 0, 0,          1, 1, 1, 32'h600));
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h300, 0, 0, 0, 0));        // alloc 01
    vt.push_back(mk(1, 32'h100, 1, 32'h100, 1, 32'h300, 1, 1, 0, 32'h300)); // read-before-write
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 1, 32'h300));
    vt.push_back(mk(0, 0,     1, 32'h100, 0, 32'h999, 0, 0, 0, 0));        // NT keeps target
    vt.push_back(mk(1, 32'h100, 0, 0, 0, 0,          1, 1, 0, 32'h300));

    n_rst = 0;
    lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
    update_taken = 0; update_target = 0; update_mispredict = 0; flush_req = 0;
    model_reset();
    #12;
    chk("rst_pvalid", {31'd0, predict_valid}, 32'd0);
    chk("rst_hit",    {31'd0, predict_hit},   32'd0);
    chk("rst_target", predict_target, 32'd0);
    chk("rst_ready",  {31'd0, ready}, 32'd0);
    chk("rst_stat",   stat_updates, 32'd0);
    n_rst = 1;

    // Clear walk: lookup during CLEAR misses; ready rises after 16 edges
    cyc(1, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("clr_lookup_valid", {31'd0, predict_valid}, 32'd1);
    chk("clr_lookup_hit",   {31'd0, predict_hit},   32'd0);
    chk("clr_lookup_taken", {31'd0, predict_taken}, 32'd0);
    chk("clr_ready1", {31'd0, ready}, 32'd0);
    for (int k = 2; k <= 16; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("clr_ready", {31'd0, ready}, {31'd0, k == 16});
    end

    foreach (vt[i]) begin
      cyc(vt[i].lv, vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].utg, 0, 0);
      chk($sformatf("vec%0d_valid", i),  {31'd0, predict_valid}, {31'd0, vt[i].e_v});
      chk($sformatf("vec%0d_hit", i),    {31'd0, predict_hit},   {31'd0, vt[i].e_h});
      chk($sformatf("vec%0d_taken", i),  {31'd0, predict_taken}, {31'd0, vt[i].e_t});
      chk($sformatf("vec%0d_target", i), predict_target, vt[i].e_tg);
    end

    // Flush with a same-cycle update: update dropped, table re-cleared
    su0 = stat_updates;
    sm0 = stat_mispredicts;
    cyc(0, 0, 1, 32'h700, 1, 32'h800, 1, 1);
    chk("flush_ready", {31'd0, ready}, 32'd0);
    chk("flush_stat_upd", stat_updates, su0);
    chk("flush_stat_mis", stat_mispredicts, sm0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 1, 32'h700, 1, 32'h800, 0, 0);
      chk("flush_walk_ready", {31'd0, ready}, {31'd0, k == 16});
    end
    cyc(1, 32'h700, 0, 0, 0, 0, 0, 0);
    chk("post_flush_hit700", {31'd0, predict_hit}, 32'd0);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("post_flush_hit100", {31'd0, predict_hit}, 32'd0);
    cyc(1, 32'h500, 1, 32'h100, 1, 32'h204, 1, 0);
    chk("post_flush_hit500", {31'd0, predict_hit}, 32'd0);
`ifdef BPRED_STATS_EN
    chk("stat_upd_inc", stat_updates, su0 + 32'd1);
    chk("stat_mis_inc", stat_mispredicts, sm0 + 32'd1);
`else
    chk("stat_upd_tied", stat_updates, 32'd0);
    chk("stat_mis_tied", stat_mispredicts, 32'd0);
`endif

    // Random traffic over 4 tags x 16 indices so aliasing is frequent
    for (int n = 0; n < 800; n++) begin
      pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      cyc($urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2),
          $urandom_range(0, 2) != 0, pc, $urandom_range(0, 1) == 1,
          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1,
          $urandom_range(0, 79) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
